// File: rtl/rs_bank_pkg.sv
// rs_bank_pkg: shared CPU types for the reservation-station bank
package rs_bank_pkg;

    localparam int TAG_W        = 5;
    localparam int RS_DEPTH_MAX = 16;

    typedef logic [TAG_W-1:0] RS_tag_type;

    localparam RS_tag_type INVALID = '0;

    typedef struct packed {
        logic [31:0] A;
        logic [31:0] B;
        logic [31:0] rs2_data;
        logic [3:0]  alu_fun;
        logic [2:0]  mem_type;
        logic [6:0]  opcode;
    } task_t;

    typedef struct packed {
        RS_tag_type  tag;
        logic [31:0] data;
    } cdb_t;

    typedef struct packed {
        logic                  valid;
        logic [3:0]            alu_fun;
        logic [2:0]            mem_type;
        RS_tag_type [2:0]      tag;
        logic [2:0][31:0]      val;
        logic [2:0]            rdy;
    } rs_slot_t;

endpackage

// File: rtl/rs_slot.sv
// rs_slot: one reservation-station slot with CDB snoop and dispatch bypass
module rs_slot
    import rs_bank_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  wr_i,
    input  logic                  leave_i,
    input  task_t                 task_i,
    input  RS_tag_type [2:0]      tag_i,
    input  cdb_t                  cdb_i,
    output logic                  valid_o,
    output logic                  ready_o,
    output logic [2:0][31:0]      val_o,
    output logic [3:0]            alu_fun_o,
    output logic [2:0]            mem_type_o
);

    rs_slot_t         slot_q, slot_d;
    logic [2:0][31:0] opv;

    assign opv        = {task_i.rs2_data, task_i.B, task_i.A};
    assign valid_o    = slot_q.valid;
    assign ready_o    = slot_q.valid & (&slot_q.rdy);
    assign val_o      = slot_q.val;
    assign alu_fun_o  = slot_q.alu_fun;
    assign mem_type_o = slot_q.mem_type;

    // wakeup on CDB match, release on issue, capture on dispatch (with same-cycle CDB bypass)
    always_comb begin
        slot_d = slot_q;
        for (int n = 0; n < 3; n++)
            if (slot_q.valid && !slot_q.rdy[n] && cdb_i.tag != INVALID && slot_q.tag[n] == cdb_i.tag) begin
                slot_d.val[n] = cdb_i.data;
                slot_d.rdy[n] = 1'b1;
            end
        if (leave_i)
            slot_d.valid = 1'b0;
        if (wr_i) begin
            slot_d.valid    = 1'b1;
            slot_d.alu_fun  = task_i.alu_fun;
            slot_d.mem_type = task_i.mem_type;
            for (int n = 0; n < 3; n++) begin
                slot_d.tag[n] = tag_i[n];
                slot_d.rdy[n] = tag_i[n] == INVALID || tag_i[n] == cdb_i.tag;
                slot_d.val[n] = tag_i[n] == INVALID ? opv[n] :
                                tag_i[n] == cdb_i.tag ? cdb_i.data : 32'd0;
            end
        end
    end

    // slot register; reset and flush empty the slot
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i)
            slot_q <= '0;
        else
            slot_q <= slot_d;
    end

endmodule

// File: rtl/rs_bank.sv
// rs_bank: DEPTH-slot reservation station issuing the oldest ready slot to one FU
module rs_bank
    import rs_bank_pkg::*;
#(
    parameter RS_tag_type RS_TAG   = INVALID,
    parameter int         DEPTH    = 4,
    parameter RS_tag_type TAG_BASE = RS_tag_type'(1)
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        flush,
    input  task_t                       DISPATCH_TASK,
    input  RS_tag_type                  dest_RS,
    input  RS_tag_type                  T1,
    input  RS_tag_type                  T2,
    input  RS_tag_type                  T3,
    input  cdb_t                        cdb_in,
    input  logic                        issue_ready,
    output logic                        BUSY,
    output RS_tag_type                  alloc_tag,
    output logic [$clog2(DEPTH+1)-1:0]  free_cnt,
    output logic                        issue_valid,
    output logic [31:0]                 V1,
    output logic [31:0]                 V2,
    output logic [31:0]                 V3,
    output RS_tag_type                  rd_tag,
    output logic [3:0]                  alu_fun,
    output logic [2:0]                  mem_type
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0]        valid, ready;
    logic [2:0][31:0]        val   [DEPTH];
    logic [3:0]              fun   [DEPTH];
    logic [2:0]              mtype [DEPTH];
    logic [IW-1:0]           age_q [DEPTH];
    logic [IW-1:0]           age_d [DEPTH];
    logic [IW-1:0]           free_idx, sel;
    logic [CW-1:0]           cnt;
    logic                    found_free, any, accept, fire;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        rs_slot u_slot (
            .clk_i      (CLK),
            .rst_i      (RST),
            .flush_i    (flush),
            .wr_i       (accept && free_idx == IW'(g)),
            .leave_i    (fire && sel == IW'(g)),
            .task_i     (DISPATCH_TASK),
            .tag_i      ({T3, T2, T1}),
            .cdb_i      (cdb_in),
            .valid_o    (valid[g]),
            .ready_o    (ready[g]),
            .val_o      (val[g]),
            .alu_fun_o  (fun[g]),
            .mem_type_o (mtype[g])
        );
    end

    // occupancy, lowest empty slot and oldest ready slot
    always_comb begin
        cnt        = '0;
        free_idx   = '0;
        found_free = 1'b0;
        sel        = '0;
        any        = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + CW'(valid[i]);
            if (!valid[i] && !found_free) begin
                free_idx   = IW'(i);
                found_free = 1'b1;
            end
            if (ready[i] && (!any || age_q[i] < age_q[sel])) begin
                sel = IW'(i);
                any = 1'b1;
            end
        end
    end

    assign BUSY        = &valid;
    assign free_cnt    = CW'(DEPTH) - cnt;
    assign alloc_tag   = TAG_BASE + RS_tag_type'(free_idx);
    assign accept      = dest_RS == RS_TAG && !BUSY;
    assign issue_valid = any;
    assign fire        = any && issue_ready;
    assign V1          = any ? val[sel][0] : 32'd0;
    assign V2          = any ? val[sel][1] : 32'd0;
    assign V3          = any ? val[sel][2] : 32'd0;
    assign rd_tag      = any ? TAG_BASE + RS_tag_type'(sel) : INVALID;
    assign alu_fun     = any ? fun[sel] : 4'd0;
    assign mem_type    = any ? mtype[sel] : 3'd0;

    // ages stay dense: slots younger than the leaver close the gap, a newcomer lands behind the survivors
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_d[i] = age_q[i];
            if (fire && valid[i] && age_q[i] > age_q[sel])
                age_d[i] = age_q[i] - 1'b1;
            if (accept && free_idx == IW'(i))
                age_d[i] = IW'(cnt - CW'(fire));
        end
    end

    // age registers
    always_ff @(posedge CLK) begin
        if (RST || flush)
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        else
            for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
    end

endmodule

// File: tb/tb_rs_bank.sv
// tb_rs_bank: directed checks of dispatch, wakeup, bypass, age select, full and flush behaviour
module tb_rs_bank;
    import rs_bank_pkg::*;

    localparam RS_tag_type SEL = 5'd30;

    logic       clk = 1'b0;
    logic       rst, flush, issue_ready;
    task_t      tsk;
    RS_tag_type dest, t1, t2, t3;
    cdb_t       cdb;
    logic       busy, ivalid;
    RS_tag_type alloc_tag, rd_tag;
    logic [2:0] free_cnt;
    logic [31:0] v1, v2, v3;
    logic [3:0] alu_fun;
    logic [2:0] mem_type;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rs_bank #(.RS_TAG(SEL), .DEPTH(4), .TAG_BASE(5'd1)) dut (
        .CLK(clk), .RST(rst), .flush(flush), .DISPATCH_TASK(tsk), .dest_RS(dest),
        .T1(t1), .T2(t2), .T3(t3), .cdb_in(cdb), .issue_ready(issue_ready),
        .BUSY(busy), .alloc_tag(alloc_tag), .free_cnt(free_cnt), .issue_valid(ivalid),
        .V1(v1), .V2(v2), .V3(v3), .rd_tag(rd_tag), .alu_fun(alu_fun), .mem_type(mem_type)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input RS_tag_type a1, input RS_tag_type a2, input RS_tag_type a3,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        dest = SEL; t1 = a1; t2 = a2; t3 = a3;
        tsk = '{A: a, B: b, rs2_data: c, alu_fun: 4'd6, mem_type: 3'd2, opcode: 7'h33};
    endtask

    task automatic idle();
        dest = INVALID; t1 = INVALID; t2 = INVALID; t3 = INVALID; cdb = '0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; issue_ready = 1'b0; tsk = '0;
        idle();
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_ivalid", ivalid, 0);
        chk("rst_free", free_cnt, 4);
        chk("rst_alloc", alloc_tag, 1);

        disp(INVALID, INVALID, INVALID, 5, 7, 9);
        tick(); idle();
        chk("t1_ivalid", ivalid, 1);
        chk("t1_v1", v1, 5);
        chk("t1_v2", v2, 7);
        chk("t1_v3", v3, 9);
        chk("t1_rdtag", rd_tag, 1);
        chk("t1_fun", alu_fun, 6);
        chk("t1_mtype", mem_type, 2);
        chk("t1_free", free_cnt, 3);
        chk("t1_alloc", alloc_tag, 2);
        tick();
        chk("t1_hold", rd_tag, 1);
        issue_ready = 1'b1;
        tick(); issue_ready = 1'b0;
        chk("t1_gone", ivalid, 0);
        chk("t1_zero_v1", v1, 0);
        chk("t1_free_back", free_cnt, 4);

        disp(5'd3, INVALID, INVALID, 1, 2, 3);
        tick(); idle();
        chk("t2_wait0", ivalid, 0);
        cdb = '{tag: 5'd7, data: 32'hBB};
        tick(); cdb = '0;
        chk("t2_wait1", ivalid, 0);
        cdb = '{tag: 5'd3, data: 32'hAA};
        tick(); cdb = '0;
        chk("t2_ivalid", ivalid, 1);
        chk("t2_v1", v1, 32'hAA);
        chk("t2_v2", v2, 2);
        issue_ready = 1'b1;
        tick(); issue_ready = 1'b0;

        disp(INVALID, 5'd4, INVALID, 32'h11, 0, 0);
        cdb = '{tag: 5'd4, data: 32'h55};
        tick(); idle();
        chk("t3_ivalid", ivalid, 1);
        chk("t3_v2", v2, 32'h55);
        chk("t3_v1", v1, 32'h11);
        issue_ready = 1'b1;
        tick(); issue_ready = 1'b0;
        chk("t3_empty", free_cnt, 4);

        for (int i = 0; i < 4; i++) begin
            disp(RS_tag_type'(10 + i), INVALID, INVALID, 0, 1, 2);
            tick();
        end
        idle();
        chk("t4_busy", busy, 1);
        chk("t4_free", free_cnt, 0);
        chk("t4_ivalid", ivalid, 0);
        disp(INVALID, INVALID, INVALID, 32'h99, 0, 0);
        tick(); idle();
        chk("t4_drop_free", free_cnt, 0);
        chk("t4_drop_ivalid", ivalid, 0);
        cdb = '{tag: 5'd12, data: 32'hC2};
        tick(); cdb = '0;
        chk("t4_s2_rdtag", rd_tag, 3);
        cdb = '{tag: 5'd10, data: 32'hA0};
        tick(); cdb = '0;
        chk("t4_oldest_rdtag", rd_tag, 1);
        chk("t4_oldest_v1", v1, 32'hA0);
        issue_ready = 1'b1;
        tick(); issue_ready = 1'b0;
        chk("t4_next_rdtag", rd_tag, 3);
        chk("t4_next_v1", v1, 32'hC2);
        chk("t4_free1", free_cnt, 1);
        chk("t4_alloc", alloc_tag, 1);

        disp(INVALID, INVALID, INVALID, 32'h77, 0, 0);
        tick(); idle();
        chk("t5_busy", busy, 1);
        chk("t5_rdtag_pre", rd_tag, 3);
        disp(INVALID, INVALID, INVALID, 32'h66, 0, 0);
        issue_ready = 1'b1;
        tick(); idle(); issue_ready = 1'b0;
        chk("t5_free", free_cnt, 1);
        chk("t5_busy", busy, 0);
        chk("t5_rdtag", rd_tag, 1);
        chk("t5_v1", v1, 32'h77);
        chk("t5_alloc", alloc_tag, 3);

        issue_ready = 1'b1;
        tick(); issue_ready = 1'b0;
        disp(5'd14, INVALID, INVALID, 0, 0, 0);
        tick(); idle();
        chk("t6_pre_ivalid", ivalid, 0);
        chk("t6_pre_free", free_cnt, 1);
        flush = 1'b1;
        cdb = '{tag: 5'd11, data: 32'h123};
        tick(); flush = 1'b0; cdb = '0;
        chk("t6_free", free_cnt, 4);
        chk("t6_busy", busy, 0);
        chk("t6_ivalid", ivalid, 0);
        chk("t6_alloc", alloc_tag, 1);
        cdb = '{tag: 5'd13, data: 32'h7};
        tick(); cdb = '0;
        chk("t6_after_ivalid", ivalid, 0);
        chk("t6_after_free", free_cnt, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
